dmem_io: RTL

Data-side memory and memory-mapped I/O block on the CPU's data port. It takes the ALU result as the byte address, register B as write data and `MW` as write strobe, and returns read data combinationally so the CPU can use it as `Din` in the same cycle. It holds a 128-byte data RAM, an LED output register, a synchronized switch input, a free-running 8-bit cycle counter and a byte-wide UART transmitter with a busy/overrun status handshake.

---
 rtl/dmem_io.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/dmem_io.sv
// Data-side memory and memory-mapped I/O: 128-byte RAM, LED register, synchronized
// switches, free-running cycle counter and a byte-wide UART transmitter with busy/overrun status.
`timescale 1ns/1ps
module dmem_io #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] ADDR,
  input  logic [7:0] WDATA,
  input  logic       MW,
  input  logic [7:0] SW,
  output logic [7:0] RDATA,
  output logic [7:0] LED,
  output logic       TX,
  output logic [1:0] dbg_state
);

  localparam logic [7:0] A_LED    = 8'hF0;
  localparam logic [7:0] A_SW     = 8'hF1;
  localparam logic [7:0] A_CNT    = 8'hF2;
  localparam logic [7:0] A_TXDATA = 8'hF4;
  localparam logic [7:0] A_STATUS = 8'hF5;

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // Bus protocol: a single-cycle write strobe. Any cycle with MW=1 commits WDATA to
  // the decoded target at the next rising edge; there is no back-pressure, so a
  // TX write while the transmitter is busy is dropped and flagged as overrun.
  logic wr_ram, wr_led, wr_cnt, wr_tx, wr_stat;

  assign wr_ram  = MW & ~ADDR[7];
  assign wr_led  = MW & (ADDR == A_LED);
  assign wr_cnt  = MW & (ADDR == A_CNT);
  assign wr_tx   = MW & (ADDR == A_TXDATA);
  assign wr_stat = MW & (ADDR == A_STATUS);

  // RAM: contents survive reset, so it has no reset branch.
  logic [7:0] mem [0:127];

  always_ff @(posedge CLK) begin
    if (wr_ram) mem[ADDR[6:0]] <= WDATA;
  end

  logic [7:0] led_q;
  logic [7:0] sw_s1, sw_s2;
  logic [7:0] cnt_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      led_q <= 8'h00;
      sw_s1 <= 8'h00;
      sw_s2 <= 8'h00;
      cnt_q <= 8'h00;
    end else begin
      sw_s1 <= SW;
      sw_s2 <= sw_s1;
      if (wr_led) led_q <= WDATA;
      if (wr_cnt) cnt_q <= WDATA;
      else        cnt_q <= cnt_q + 8'd1;
    end
  end

  assign LED = led_q;

  uart_state_t   state;
  logic [CW-1:0] clk_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_q;
  logic          tx_q;
  logic          overrun_q;
  logic          busy;

  assign busy = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_idx   <= 3'd0;
      shift_q   <= 8'h00;
      tx_q      <= 1'b1;
      overrun_q <= 1'b0;
    end else begin
      if (wr_tx && busy)  overrun_q <= 1'b1;
      else if (wr_stat)   overrun_q <= 1'b0;

      case (state)
        IDLE: begin
          tx_q <= 1'b1;
          if (wr_tx) begin
            shift_q <= WDATA;
            clk_cnt <= '0;
            tx_q    <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (clk_cnt == LAST_CLK) begin
            clk_cnt <= '0;
            bit_idx <= 3'd0;
            tx_q    <= shift_q[0];
            state   <= DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (clk_cnt == LAST_CLK) begin
            clk_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx_q  <= 1'b1;
              state <= STOP;
            end else begin
              // Shift right so the next bit to send is always in bit 1 before the shift.
              tx_q    <= shift_q[1];
              shift_q <= {1'b0, shift_q[7:1]};
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        STOP: begin
          if (clk_cnt == LAST_CLK) begin
            clk_cnt <= '0;
            state   <= IDLE;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: begin
          tx_q  <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

  assign TX        = tx_q;
  assign dbg_state = state;

  always_comb begin
    RDATA = 8'h00;
    if (!ADDR[7]) begin
      RDATA = mem[ADDR[6:0]];
    end else begin
      case (ADDR)
        A_LED:    RDATA = led_q;
        A_SW:     RDATA = sw_s2;
        A_CNT:    RDATA = cnt_q;
        A_STATUS: RDATA = {6'b0, overrun_q, busy};
        default:  RDATA = 8'h00;
      endcase
    end
  end

endmodule
